// File: rtl/twiddle_loader.sv
// twiddle_loader
//
// Streams one stage's worth of FFT twiddle coefficients into a downstream
// coefficient bank. A start request launches a burst of N/2 writes. Each
// write carries:
//    - the cosine value,
//    - the precomputed sum cos+sin,
//    - the precomputed difference cos-sin,
// taken from a Q1.7 table. The table is strided by the selected FFT stage.
//
// Optional feature:
//    TWIDDLE_LOADER_AUTOSTART_EN - when defined, a stage-0 load launches by
//    itself on the first cycle after reset is released.
//
// Ports:
//    clk      - single clock, all state changes on its rising edge
//    reset    - synchronous, active-high reset
//    start    - one-cycle load request (ignored while busy)
//    stage    - FFT stage select, latched when a load begins
//    we       - bank write enable, high for N/2 consecutive cycles
//    addr     - bank write address, 0..N/2-1
//    c_out    - signed cosine coefficient, MSB bits
//    cps_out  - signed cos+sin, MSB+1 bits
//    cms_out  - signed cos-sin, MSB+1 bits
//    busy     - high while a load (including its done cycle) is in progress
//    done     - one-cycle completion pulse
module twiddle_loader #(
    parameter int N   = 16,
    parameter int MSB = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2($clog2(N))-1:0]  stage,
    output logic                          we,
    output logic [$clog2(N/2)-1:0]        addr,
    output logic signed [MSB-1:0]         c_out,
    output logic signed [MSB:0]           cps_out,
    output logic signed [MSB:0]           cms_out,
    output logic                          busy,
    output logic                          done
);

    localparam int  HALF = N / 2;
    localparam int  AW   = $clog2(HALF);
    localparam int  SW   = $clog2($clog2(N));
    localparam real PI   = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state;
    logic [SW-1:0]           stage_q;
    logic signed [MSB-1:0]   c_tab [HALF];
    logic signed [MSB-1:0]   s_tab [HALF];
    logic [AW-1:0]           addr_inc;
    logic [AW-1:0]           k_sel;
    logic signed [MSB:0]     c_ext;
    logic signed [MSB:0]     s_ext;
    logic                    go;
    logic [SW-1:0]           go_stage;

    // Coefficient table, evaluated at elaboration time.
    // int'() rounds to nearest, which matches round(127*cos/sin).
    for (genvar g = 0; g < HALF; g++) begin : g_tab
        localparam int CV = int'(127.0 * $cos(2.0 * PI * g / N));
        localparam int SV = int'(127.0 * $sin(2.0 * PI * g / N));
        assign c_tab[g] = MSB'(CV);
        assign s_tab[g] = MSB'(SV);
    end

`ifdef TWIDDLE_LOADER_AUTOSTART_EN
    // Set by reset, consumed on the first cycle reset is low. It stands in
    // for a start pulse with stage 0.
    logic autostart_pending;

    always_ff @(posedge clk) begin
        if (reset)
            autostart_pending <= 1'b1;
        else
            autostart_pending <= 1'b0;
    end

    always_comb begin
        go       = start | autostart_pending;
        go_stage = autostart_pending ? '0 : stage;
    end
`else
    always_comb begin
        go       = start;
        go_stage = stage;
    end
`endif

    // Outputs are registered, so the table is looked up for the address
    // that is about to be issued. Truncating the shift to AW bits gives
    // the mod N/2 wrap for free.
    always_comb begin
        addr_inc = addr + 1'b1;
        k_sel    = (state == IDLE) ? '0 : AW'(addr_inc << stage_q);
        c_ext    = {c_tab[k_sel][MSB-1], c_tab[k_sel]};
        s_ext    = {s_tab[k_sel][MSB-1], s_tab[k_sel]};
    end

    // Control FSM with registered outputs.
    // Data outputs hold their last value whenever no write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            stage_q <= '0;
            we      <= 1'b0;
            addr    <= '0;
            c_out   <= '0;
            cps_out <= '0;
            cms_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        state   <= LOAD;
                        stage_q <= go_stage;
                        addr    <= '0;
                        we      <= 1'b1;
                        busy    <= 1'b1;
                        c_out   <= c_tab[k_sel];
                        cps_out <= c_ext + s_ext;
                        cms_out <= c_ext - s_ext;
                    end
                end
                LOAD: begin
                    if (addr == AW'(HALF - 1)) begin
                        state <= DONE;
                        we    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        addr    <= addr_inc;
                        we      <= 1'b1;
                        c_out   <= c_tab[k_sel];
                        cps_out <= c_ext + s_ext;
                        cms_out <= c_ext - s_ext;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twiddle_loader.sv
// tb_twiddle_loader
//
// Testbench for twiddle_loader with N=16 and MSB=8.
//
// A cycle-level reference model tracks how many cycles have passed since a
// load was accepted. From that count it derives the expected value of every
// output. Coefficients are computed with real trigonometry.
//
// On top of the model, the bench adds:
//    - a table of spot values,
//    - hand sequences for mid-load restarts, reset aborts and autostart,
//    - a randomized phase.
module tb_twiddle_loader;

    localparam int  N    = 16;
    localparam int  HALF = N / 2;
    localparam real PI   = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] stage;
    logic       we;
    logic [2:0] addr;
    logic [7:0] c_out;
    logic [8:0] cps_out;
    logic [8:0] cms_out;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    // m_cnt is 0 when idle, otherwise cycles since the load was accepted.
    int         m_cnt   = 0;
    int         m_stage = 0;
    logic       m_pend  = 1'b0;
    logic       e_we, e_busy, e_done;
    logic [2:0] e_addr;
    logic [7:0] e_c;
    logic [8:0] e_cps, e_cms;

    typedef struct {
        logic [1:0] stage;
        int         addr;
        logic [7:0] c;
        logic [8:0] cps;
        logic [8:0] cms;
    } vec_t;

    vec_t vecs[8];

    twiddle_loader #(.N(N), .MSB(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stage(stage),
        .we(we), .addr(addr), .c_out(c_out), .cps_out(cps_out),
        .cms_out(cms_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int tcos(int k);
        return int'(127.0 * $cos(2.0 * PI * k / N));
    endfunction

    function automatic int tsin(int k);
        return int'(127.0 * $sin(2.0 * PI * k / N));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advances the model by one rising edge, given the inputs sampled there.
    task automatic modelStep(input logic r, input logic s, input logic [1:0] st);
        logic go;
        int   gs;
        int   a;
        int   k;
        if (r) begin
            m_cnt  = 0;
            m_pend = 1'b1;
            e_we = 0; e_busy = 0; e_done = 0;
            e_addr = 0; e_c = 0; e_cps = 0; e_cms = 0;
        end else begin
            go = s;
            gs = st;
`ifdef TWIDDLE_LOADER_AUTOSTART_EN
            if (m_pend) begin
                go = 1'b1;
                gs = 0;
            end
`endif
            m_pend = 1'b0;
            if (m_cnt == 0) begin
                if (go) begin
                    m_cnt   = 1;
                    m_stage = gs;
                end
            end else begin
                m_cnt++;
                if (m_cnt > HALF + 1) m_cnt = 0;
            end
            e_we   = (m_cnt >= 1) && (m_cnt <= HALF);
            e_done = (m_cnt == HALF + 1);
            e_busy = (m_cnt >= 1);
            if (e_we) begin
                a      = m_cnt - 1;
                k      = (a * (1 << m_stage)) % HALF;
                e_addr = 3'(a);
                e_c    = 8'(tcos(k));
                e_cps  = 9'(tcos(k) + tsin(k));
                e_cms  = 9'(tcos(k) - tsin(k));
            end
        end
    endtask

    task automatic checkOutput();
        check("we",      int'(we),      int'(e_we));
        check("busy",    int'(busy),    int'(e_busy));
        check("done",    int'(done),    int'(e_done));
        check("addr",    int'(addr),    int'(e_addr));
        check("c_out",   int'(c_out),   int'(e_c));
        check("cps_out", int'(cps_out), int'(e_cps));
        check("cms_out", int'(cms_out), int'(e_cms));
    endtask

    // Drives inputs away from the edge, clocks once, then compares
    // against the model.
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] st);
        reset = r;
        start = s;
        stage = st;
        @(posedge clk);
        modelStep(r, s, st);
        #1;
        checkOutput();
    endtask

    // Resets, then idles long enough for any automatic load to drain.
    task automatic resetAndSettle();
        applyStimulus(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < N + 4; i++) applyStimulus(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        int dones;

        // Spot values: stage, addr, c_out, cps_out, cms_out.
        vecs[0] = '{2'd0, 2, 8'h5a, 9'h0b4, 9'h000};
        vecs[1] = '{2'd1, 3, 8'ha6, 9'h000, 9'h14c};
        vecs[2] = '{2'd3, 0, 8'h7f, 9'h07f, 9'h07f};
        vecs[3] = '{2'd3, 7, 8'h7f, 9'h07f, 9'h07f};
        vecs[4] = '{2'd0, 0, 8'h7f, 9'h07f, 9'h07f};
        vecs[5] = '{2'd0, 4, 8'h00, 9'h07f, 9'h181};
        vecs[6] = '{2'd2, 1, 8'h00, 9'h07f, 9'h181};
        vecs[7] = '{2'd0, 7, 8'h8b, 9'h1bc, 9'h15a};

        reset = 1'b1;
        start = 1'b0;
        stage = 2'd0;

        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b1, 1'b1, 2'd0);
        check("reset_we", int'(we), 0);
        check("reset_busy", int'(busy), 0);

`ifdef TWIDDLE_LOADER_AUTOSTART_EN
        // Releasing reset alone launches a stage-0 load.
        applyStimulus(1'b0, 1'b0, 2'd0);
        check("autostart_we", int'(we), 1);
        check("autostart_addr", int'(addr), 0);
        check("autostart_c", int'(c_out), 32'h7f);
        applyStimulus(1'b0, 1'b0, 2'd0);
        check("autostart_addr1", int'(addr), 1);
`endif

        // Table-driven spot values.
        // The stage input is scrambled during the load to show it is ignored.
        for (int v = 0; v < 8; v++) begin
            resetAndSettle();
            applyStimulus(1'b0, 1'b1, vecs[v].stage);
            dones = 0;
            for (int i = 0; i < HALF; i++) begin
                if (i > 0) applyStimulus(1'b0, 1'b0, 2'($urandom_range(0, 3)));
                if (i == vecs[v].addr) begin
                    check("vec_addr", int'(addr),    vecs[v].addr);
                    check("vec_c",    int'(c_out),   int'(vecs[v].c));
                    check("vec_cps",  int'(cps_out), int'(vecs[v].cps));
                    check("vec_cms",  int'(cms_out), int'(vecs[v].cms));
                end
            end
            applyStimulus(1'b0, 1'b0, 2'd0);
            check("vec_done_at_9", int'(done), 1);
            applyStimulus(1'b0, 1'b0, 2'd0);
            check("vec_idle_busy", int'(busy), 0);
        end

        // Second start at addr=4 with a different stage is ignored.
        resetAndSettle();
        applyStimulus(1'b0, 1'b1, 2'd0);
        dones = 0;
        for (int i = 1; i < HALF + 4; i++) begin
            applyStimulus(1'b0, (i == 4), (i == 4) ? 2'd3 : 2'd0);
            if (done) dones++;
        end
        check("midload_single_done", dones, 1);

        // Reset at addr=5 aborts the load.
        resetAndSettle();
        applyStimulus(1'b0, 1'b1, 2'd1);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 2'd1);
        check("abort_addr_before", int'(addr), 5);
        applyStimulus(1'b1, 1'b0, 2'd0);
        check("abort_we", int'(we), 0);
        check("abort_busy", int'(busy), 0);
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        for (int i = 0; i < N + 4; i++) applyStimulus(1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        check("restart_addr", int'(addr), 0);
        check("restart_we", int'(we), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/twiddle_loader.md
TWIDDLE_LOADER -- requirements
Module: twiddle_loader

Interface
REQ-001 SHALL have parameter N, default 16, meaning FFT length; power of two, at least 4.
REQ-002 SHALL have parameter MSB, default 8, meaning coefficient width (c_out is MSB bits; cps_out/cms_out are MSB+1 bits).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle load request.
REQ-006 SHALL have port stage  input  $clog2($clog2(N))  FFT stage select, 0..log2(N)-1.
REQ-007 SHALL have port we  output  1  bank write enable.
REQ-008 SHALL have port addr  output  $clog2(N/2)  bank write address.
REQ-009 SHALL have port c_out  output  MSB  signed cosine, Q1.7.
REQ-010 SHALL have port cps_out  output  MSB+1  signed cos+sin.
REQ-011 SHALL have port cms_out  output  MSB+1  signed cos-sin.
REQ-012 SHALL have port busy  output  1  high while a load is in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL hold an internal constant table, k=0..N/2-1: C[k]=round(127*cos(2*pi*k/N)) and S[k]=round(127*sin(2*pi*k/N)); for N=16, C = 127,117,90,49,0,-49,-90,-117 and S = 0,49,90,117,127,117,90,49.
REQ-015 SHALL implement FSM states IDLE, LOAD and DONE; the reset state is IDLE.
REQ-016 SHALL, in IDLE, on start=1, latch stage, clear the address counter and enter LOAD.
REQ-017 SHALL, in LOAD, assert we=1 for exactly N/2 consecutive cycles, with addr stepping 0,1,...,N/2-1 (one entry per cycle).
REQ-018 SHALL compute table index k=(addr<<stage_latched) mod N/2 and drive c_out=C[k], cps_out=C[k]+S[k] and cms_out=C[k]-S[k] (all sign-extended to MSB+1 bits) in the same cycle as we and addr.
REQ-019 SHALL drive we, addr, c_out, cps_out and cms_out from registers, so they are stable across the falling edge on which the downstream bank writes.
REQ-020 SHALL go from LOAD to DONE after addr=N/2-1 is issued, hold done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL assert busy=1 in LOAD and DONE only.
REQ-022 SHALL ignore start while busy=1, and SHALL ignore changes on stage during LOAD.
REQ-023 SHALL drive we=0 and hold addr, c_out, cps_out and cms_out at their last values when not in LOAD.
REQ-024 SHALL make the latency from start sampled to the first we=1 exactly 1 cycle, and from start to done exactly N/2+1 cycles.

Reset
REQ-025 SHALL, while reset=1 at a clock edge, put the FSM in IDLE and drive we=0, busy=0, done=0, addr=0, c_out=0, cps_out=0, cms_out=0.
REQ-026 SHALL let reset override start; a reset during LOAD aborts the load on that edge with no further writes and no done pulse.

Configuration
REQ-027 SHALL support the macro TWIDDLE_LOADER_AUTOSTART_EN: when defined, a load with stage=0 starts automatically on the first cycle after reset deasserts, exactly as if start=1; when undefined, loads start only on start.

Verification
REQ-028 SHALL be verified by: reset, start pulse with stage=0 -> we high for 8 cycles, addr 0..7, and at addr=2: c_out=8'h5a, cps_out=9'h0b4, cms_out=9'h000; done pulses at cycle 9.
REQ-029 SHALL be verified by: start with stage=1 -> at addr=3, k=6: c_out=8'ha6, cps_out=9'h000, cms_out=9'h14c.
REQ-030 SHALL be verified by: start with stage=3 -> all 8 writes give c_out=8'h7f, cps_out=9'h07f, cms_out=9'h07f.
REQ-031 SHALL be verified by: second start at addr=4 mid-load, with stage toggled -> sequence unchanged, single done.
REQ-032 SHALL be verified by: reset asserted at addr=5 -> we=0 on the next cycle, busy=0, no done; a fresh start then restarts at addr=0.
REQ-033 SHALL be verified by: TWIDDLE_LOADER_AUTOSTART_EN defined, reset released with no start -> stage-0 load begins one cycle later.
